// File: rtl/loop_trace_monitor_if.sv
// Bundle between the bounded-loop counter stage taps and its trace monitor.
// Carries the sampled stage signals (sel, x, m, n) and the monitor verdict/statistics.
// master: whoever drives the stage taps (stage wrapper or bench); slave: the monitor.
interface loop_trace_monitor_if #(
    parameter int W  = 11,
    parameter int CW = 16
);
    logic          sel;
    logic [W-1:0]  x;
    logic [W-1:0]  m;
    logic [W-1:0]  n;
    logic [1:0]    state;
    logic          done;
    logic          fail;
    logic [5:0]    fail_mask;
    logic [CW-1:0] fail_cycle;
    logic [CW-1:0] done_cycle;
    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] upd_cnt;

    modport master (
        output sel, x, m, n,
        input  state, done, fail, fail_mask, fail_cycle, done_cycle, sample_cnt, upd_cnt
    );

    modport slave (
        input  sel, x, m, n,
        output state, done, fail, fail_mask, fail_cycle, done_cycle, sample_cnt, upd_cnt
    );
endinterface

// File: rtl/loop_trace_monitor.sv
// Trace monitor for the bounded-loop counter stage (x counts 0..n, m captures x on sel, n held).
// Ports: clk, rst (sync, active-high), bus (slave): sel/x/m/n in; state, done, fail, fail_mask,
// fail_cycle, done_cycle, sample_cnt, upd_cnt out. All outputs registered, verdict one cycle after sample.
module loop_trace_monitor #(
    parameter int W      = 11,
    parameter int N_INIT = 500,
    parameter int CW     = 16
) (
    input  logic               clk,
    input  logic               rst,
    loop_trace_monitor_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [W-1:0]  N_INIT_W = W'(N_INIT);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic [1:0]    state_q;
    logic [5:0]    fail_mask_q;
    logic [CW-1:0] fail_cycle_q;
    logic [CW-1:0] done_cycle_q;
    logic [CW-1:0] sample_cnt_q;
    logic [CW-1:0] upd_cnt_q;

    // Previous sample
    logic [W-1:0]  px_q;
    logic [W-1:0]  pm_q;
    logic [W-1:0]  pn_q;
    logic          psel_q;

    logic          first;
    logic          act;
    logic [W:0]    px_inc;
    logic [5:0]    mask;
    logic          term;
    logic [CW-1:0] idx;
    logic [CW-1:0] upd_nxt;

    // IDLE is only ever occupied between reset and sample 1, so it marks the first sample.
    assign first  = (state_q == S_IDLE);
    assign act    = (px_q < pn_q);
    // One extra bit so a stage that wraps 2^W-1 -> 0 is caught as a bad step.
    assign px_inc = {1'b0, px_q} + {{W{1'b0}}, 1'b1};
    assign term   = (bus.x >= bus.n);

    always_comb begin
        mask    = 6'b0;
        mask[0] = first && !((bus.x == '0) && (bus.m == '0) && (bus.n == N_INIT_W));
        if (!first) begin
            mask[1] = act ? ({1'b0, bus.x} != px_inc) : (bus.x != px_q);
            mask[2] = (act && psel_q) ? (bus.m != px_q) : (bus.m != pm_q);
            mask[3] = (bus.n != pn_q);
        end
        mask[4] = term && (bus.n != '0) && (bus.m >= bus.n);
        mask[5] = (bus.x > bus.n);
    end

    // Index of the sample being taken on this edge (saturating).
    assign idx     = (sample_cnt_q == CNT_MAX) ? sample_cnt_q : sample_cnt_q + 1'b1;
    assign upd_nxt = (upd_cnt_q == CNT_MAX) ? upd_cnt_q : upd_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fail_mask_q  <= 6'b0;
            fail_cycle_q <= '0;
            done_cycle_q <= '0;
            sample_cnt_q <= '0;
            upd_cnt_q    <= '0;
            px_q         <= '0;
            pm_q         <= '0;
            pn_q         <= '0;
            psel_q       <= 1'b0;
        end else begin
            px_q         <= bus.x;
            pm_q         <= bus.m;
            pn_q         <= bus.n;
            psel_q       <= bus.sel;
            sample_cnt_q <= idx;
            if (!first && act && psel_q) begin
                upd_cnt_q <= upd_nxt;
            end

            case (state_q)
                S_IDLE, S_RUN: begin
                    // A failing termination sample goes to FAIL without recording done_cycle.
                    if (|mask) begin
                        state_q      <= S_FAIL;
                        fail_mask_q  <= mask;
                        fail_cycle_q <= idx;
                    end else if (term) begin
                        state_q      <= S_DONE;
                        done_cycle_q <= idx;
                    end else begin
                        state_q      <= S_RUN;
                    end
                end
                S_DONE: begin
                    // act is false here, so C1/C2 already demand x, m held.
                    if (|mask) begin
                        state_q      <= S_FAIL;
                        fail_mask_q  <= mask;
                        fail_cycle_q <= idx;
                    end
                end
                default: begin
                    state_q <= S_FAIL;
                end
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.done       = (state_q == S_DONE);
    assign bus.fail       = (state_q == S_FAIL);
    assign bus.fail_mask  = fail_mask_q;
    assign bus.fail_cycle = fail_cycle_q;
    assign bus.done_cycle = done_cycle_q;
    assign bus.sample_cnt = sample_cnt_q;
    assign bus.upd_cnt    = upd_cnt_q;
endmodule

// File: tb/tb_loop_trace_monitor.sv
// Directed bench for loop_trace_monitor: a behavioural upstream stage for nominal runs,
// plus direct drive of x/m/n/sel for fault injection.
// Inputs change and outputs are checked on the falling edge.
module tb_loop_trace_monitor;
    localparam int W  = 11;
    localparam int CW = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic          use_stage;
    logic          drv_sel;
    logic [W-1:0]  drv_x, drv_m, drv_n;
    logic [W-1:0]  st_x, st_m, st_n;

    loop_trace_monitor_if #(.W(W), .CW(CW)) ifc ();

    loop_trace_monitor #(.W(W), .N_INIT(500), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    assign ifc.sel = drv_sel;
    assign ifc.x   = use_stage ? st_x : drv_x;
    assign ifc.m   = use_stage ? st_m : drv_m;
    assign ifc.n   = use_stage ? st_n : drv_n;

    // Upstream bounded-loop stage model
    always @(posedge clk) begin
        if (rst) begin
            st_x <= '0;
            st_m <= '0;
            st_n <= 11'd500;
        end else if (st_x < st_n) begin
            st_x <= st_x + 1'b1;
            if (drv_sel) st_m <= st_x;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Let the stage run for cnt samples; optionally toggle sel after each.
    task automatic run_edges(input int cnt, input bit toggle);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (toggle) drv_sel = ~drv_sel;
        end
    endtask

    task automatic drive_sample(input logic [W-1:0] xv, input logic [W-1:0] mv,
                                input logic [W-1:0] nv, input logic s);
        drv_x   = xv;
        drv_m   = mv;
        drv_n   = nv;
        drv_sel = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        use_stage = 1'b1;
        drv_sel   = 1'b1;
        do_reset();
        total++; if (ifc.state !== 2'd0)      begin bad++; $display("FAIL reset_state: got %0d expected 0", ifc.state); end
        total++; if (ifc.done !== 1'b0)       begin bad++; $display("FAIL reset_done: got %0d expected 0", ifc.done); end
        total++; if (ifc.fail !== 1'b0)       begin bad++; $display("FAIL reset_fail: got %0d expected 0", ifc.fail); end
        total++; if (ifc.fail_mask !== 6'd0)  begin bad++; $display("FAIL reset_mask: got %b expected 000000", ifc.fail_mask); end
        total++; if (ifc.fail_cycle !== 16'd0) begin bad++; $display("FAIL reset_fail_cycle: got %0d expected 0", ifc.fail_cycle); end
        total++; if (ifc.done_cycle !== 16'd0) begin bad++; $display("FAIL reset_done_cycle: got %0d expected 0", ifc.done_cycle); end
        total++; if (ifc.sample_cnt !== 16'd0) begin bad++; $display("FAIL reset_sample_cnt: got %0d expected 0", ifc.sample_cnt); end
        total++; if (ifc.upd_cnt !== 16'd0)   begin bad++; $display("FAIL reset_upd_cnt: got %0d expected 0", ifc.upd_cnt); end
    endtask

    task automatic test_nominal();
        use_stage = 1'b1;
        drv_sel   = 1'b1;
        do_reset();
        run_edges(1, 1'b0);
        total++; if (ifc.state !== 2'd1) begin bad++; $display("FAIL nom_first_state: got %0d expected 1", ifc.state); end
        run_edges(499, 1'b0);
        total++; if (ifc.state !== 2'd1) begin bad++; $display("FAIL nom_s500_state: got %0d expected 1", ifc.state); end
        run_edges(1, 1'b0);
        total++; if (ifc.done !== 1'b1)         begin bad++; $display("FAIL nom_done: got %0d expected 1", ifc.done); end
        total++; if (ifc.done_cycle !== 16'd501) begin bad++; $display("FAIL nom_done_cycle: got %0d expected 501", ifc.done_cycle); end
        total++; if (ifc.upd_cnt !== 16'd500)   begin bad++; $display("FAIL nom_upd_cnt: got %0d expected 500", ifc.upd_cnt); end
        total++; if (ifc.m !== 11'd499)         begin bad++; $display("FAIL nom_final_m: got %0d expected 499", ifc.m); end
        for (int i = 0; i < 20; i++) begin
            run_edges(1, 1'b0);
            total++; if (ifc.state !== 2'd2) begin bad++; $display("FAIL nom_hold_state[%0d]: got %0d expected 2", i, ifc.state); end
        end
        total++; if (ifc.sample_cnt !== 16'd521) begin bad++; $display("FAIL nom_sample_cnt: got %0d expected 521", ifc.sample_cnt); end
        total++; if (ifc.fail !== 1'b0)          begin bad++; $display("FAIL nom_fail: got %0d expected 0", ifc.fail); end
        total++; if (ifc.upd_cnt !== 16'd500)    begin bad++; $display("FAIL nom_upd_hold: got %0d expected 500", ifc.upd_cnt); end
    endtask

    task automatic test_sel_pattern();
        use_stage = 1'b1;
        drv_sel   = 1'b1;
        do_reset();
        run_edges(501, 1'b1);
        total++; if (ifc.upd_cnt !== 16'd250)    begin bad++; $display("FAIL sel_upd_cnt: got %0d expected 250", ifc.upd_cnt); end
        total++; if (ifc.done_cycle !== 16'd501) begin bad++; $display("FAIL sel_done_cycle: got %0d expected 501", ifc.done_cycle); end
        total++; if (ifc.m !== 11'd498)          begin bad++; $display("FAIL sel_final_m: got %0d expected 498", ifc.m); end
        total++; if (ifc.fail !== 1'b0)          begin bad++; $display("FAIL sel_fail: got %0d expected 0", ifc.fail); end
        total++; if (ifc.done !== 1'b1)          begin bad++; $display("FAIL sel_done: got %0d expected 1", ifc.done); end
    endtask

    task automatic test_step_inject();
        use_stage = 1'b0;
        do_reset();
        for (int k = 1; k <= 9; k++) drive_sample(11'(k - 1), 11'd0, 11'd500, 1'b0);
        total++; if (ifc.fail !== 1'b0) begin bad++; $display("FAIL step_pre_fail: got %0d expected 0", ifc.fail); end
        drive_sample(11'd10, 11'd0, 11'd500, 1'b0);
        total++; if (ifc.fail !== 1'b1)          begin bad++; $display("FAIL step_fail: got %0d expected 1", ifc.fail); end
        total++; if (ifc.fail_mask !== 6'b000010) begin bad++; $display("FAIL step_mask: got %b expected 000010", ifc.fail_mask); end
        total++; if (ifc.fail_cycle !== 16'd10)  begin bad++; $display("FAIL step_cycle: got %0d expected 10", ifc.fail_cycle); end
        drive_sample(11'd0, 11'd300, 11'd7, 1'b1);
        drive_sample(11'd2000, 11'd2000, 11'd5, 1'b0);
        total++; if (ifc.fail_mask !== 6'b000010) begin bad++; $display("FAIL step_mask_frozen: got %b expected 000010", ifc.fail_mask); end
        total++; if (ifc.fail_cycle !== 16'd10)  begin bad++; $display("FAIL step_cycle_frozen: got %0d expected 10", ifc.fail_cycle); end
        total++; if (ifc.state !== 2'd3)         begin bad++; $display("FAIL step_state: got %0d expected 3", ifc.state); end
        total++; if (ifc.sample_cnt !== 16'd12)  begin bad++; $display("FAIL step_sample_cnt: got %0d expected 12", ifc.sample_cnt); end
    endtask

    task automatic test_init_inject();
        use_stage = 1'b0;
        do_reset();
        drive_sample(11'd0, 11'd0, 11'd499, 1'b0);
        total++; if (ifc.fail_mask !== 6'b000001) begin bad++; $display("FAIL init_mask: got %b expected 000001", ifc.fail_mask); end
        total++; if (ifc.fail_cycle !== 16'd1)   begin bad++; $display("FAIL init_cycle: got %0d expected 1", ifc.fail_cycle); end
        total++; if (ifc.done !== 1'b0)          begin bad++; $display("FAIL init_done: got %0d expected 0", ifc.done); end
        // n==0: init fails, safety does not (gated by n!=0)
        do_reset();
        drive_sample(11'd0, 11'd0, 11'd0, 1'b0);
        total++; if (ifc.fail_mask !== 6'b000001) begin bad++; $display("FAIL init_n0_mask: got %b expected 000001", ifc.fail_mask); end
        total++; if (ifc.done_cycle !== 16'd0)   begin bad++; $display("FAIL init_n0_done_cycle: got %0d expected 0", ifc.done_cycle); end
    endtask

    task automatic test_safety_bound();
        use_stage = 1'b0;
        do_reset();
        drive_sample(11'd0, 11'd0, 11'd500, 1'b1);
        total++; if (ifc.state !== 2'd1) begin bad++; $display("FAIL sb_s1_state: got %0d expected 1", ifc.state); end
        drive_sample(11'd501, 11'd600, 11'd500, 1'b0);
        total++; if (ifc.fail_mask !== 6'b110110) begin bad++; $display("FAIL sb_mask: got %b expected 110110", ifc.fail_mask); end
        total++; if (ifc.fail_cycle !== 16'd2)   begin bad++; $display("FAIL sb_cycle: got %0d expected 2", ifc.fail_cycle); end
    endtask

    task automatic test_term_fail();
        use_stage = 1'b0;
        do_reset();
        for (int k = 1; k <= 500; k++) drive_sample(11'(k - 1), 11'd0, 11'd500, 1'b0);
        drive_sample(11'd500, 11'd5, 11'd500, 1'b0);
        total++; if (ifc.state !== 2'd3)          begin bad++; $display("FAIL term_state: got %0d expected 3", ifc.state); end
        total++; if (ifc.done_cycle !== 16'd0)    begin bad++; $display("FAIL term_done_cycle: got %0d expected 0", ifc.done_cycle); end
        total++; if (ifc.fail_mask !== 6'b000100) begin bad++; $display("FAIL term_mask: got %b expected 000100", ifc.fail_mask); end
        total++; if (ifc.fail_cycle !== 16'd501)  begin bad++; $display("FAIL term_cycle: got %0d expected 501", ifc.fail_cycle); end
    endtask

    task automatic test_reset_midrun();
        use_stage = 1'b1;
        drv_sel   = 1'b1;
        do_reset();
        run_edges(199, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (ifc.state !== 2'd0)       begin bad++; $display("FAIL mid_state: got %0d expected 0", ifc.state); end
        total++; if (ifc.sample_cnt !== 16'd0) begin bad++; $display("FAIL mid_sample_cnt: got %0d expected 0", ifc.sample_cnt); end
        total++; if (ifc.upd_cnt !== 16'd0)    begin bad++; $display("FAIL mid_upd_cnt: got %0d expected 0", ifc.upd_cnt); end
        total++; if (ifc.done_cycle !== 16'd0) begin bad++; $display("FAIL mid_done_cycle: got %0d expected 0", ifc.done_cycle); end
        total++; if (ifc.fail !== 1'b0)        begin bad++; $display("FAIL mid_fail: got %0d expected 0", ifc.fail); end
        rst = 1'b0;
        run_edges(501, 1'b0);
        total++; if (ifc.done_cycle !== 16'd501) begin bad++; $display("FAIL mid_rerun_done_cycle: got %0d expected 501", ifc.done_cycle); end
        total++; if (ifc.done !== 1'b1)          begin bad++; $display("FAIL mid_rerun_done: got %0d expected 1", ifc.done); end
        total++; if (ifc.upd_cnt !== 16'd500)    begin bad++; $display("FAIL mid_rerun_upd_cnt: got %0d expected 500", ifc.upd_cnt); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        use_stage = 1'b1;
        drv_sel   = 1'b1;
        drv_x     = '0;
        drv_m     = '0;
        drv_n     = '0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_sel_pattern();
        test_step_inject();
        test_init_inject();
        test_safety_bound();
        test_term_fail();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
